clkdiv_sched: RTL and testbench

- Programmable controller for the 50 MHz-to-low-frequency divider datapath.
- Sequences the divided clock through start, stop and N-period bursts.
- Accepts new divisor values over a valid/ready handshake and applies each one only at a half-period boundary, so clkHz never emits a runt pulse.
- Sits between the system 50 MHz clock and the downstream blocks (debouncers, display mux, timers) that consume clkHz or tick.

---
 rtl/clkdiv_sched.sv | 137 +++++++++++++
 tb/tb_clkdiv_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_sched.sv
// Programmable clock divider controller: start/stop/burst sequencing of a divided clock,
// with divisor updates deferred to half-period boundaries so clkHz never emits a runt pulse.
module clkdiv_sched #(
    parameter int WIDTH       = 18,
    parameter int DEFAULT_DIV = 250000,
    parameter int BURST_W     = 8
) (
    input  logic               clkMHz,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               cfg_valid,
    input  logic [WIDTH-1:0]   cfg_div,
    output logic               cfg_ready,
    output logic               clkHz,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   div_active;
    logic [WIDTH-1:0]   div_shadow;
    logic [WIDTH-1:0]   cnt;
    logic               pend;
    logic [BURST_W-1:0] pcnt;
    logic [BURST_W-1:0] blen;

    logic boundary;
    logic fall;
    logic last_period;
    logic burst_end;
    logic stop_low;
    logic to_idle;

    assign boundary    = busy && (cnt == div_active);
    assign fall        = boundary && clkHz;
    assign last_period = (blen != '0) && ((pcnt + BURST_W'(1)) == blen);
    assign burst_end   = (state == RUN) && fall && last_period;
    // Stopping while low can end at once: the output is already in its idle level.
    assign stop_low    = (state == RUN) && stop && !clkHz;
    assign to_idle     = burst_end || stop_low || (fall && stop);

    always_ff @(negedge clkMHz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (to_idle) begin
                    state_next = IDLE;
                end else if (stop) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        cfg_ready = ~pend;
    end

    always_ff @(negedge clkMHz or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            clkHz <= 1'b0;
            tick  <= 1'b0;
            done  <= 1'b0;
            pcnt  <= '0;
            blen  <= '0;
        end else if (state == IDLE) begin
            cnt   <= '0;
            clkHz <= 1'b0;
            tick  <= 1'b0;
            done  <= 1'b0;
            if (start) begin
                blen <= burst_len;
                pcnt <= '0;
            end
        end else if (stop_low) begin
            cnt   <= '0;
            clkHz <= 1'b0;
            tick  <= 1'b0;
            done  <= 1'b0;
        end else if (boundary) begin
            cnt   <= '0;
            clkHz <= ~clkHz;
            tick  <= 1'b1;
            done  <= burst_end;
            if (fall) begin
                pcnt <= pcnt + BURST_W'(1);
            end
        end else begin
            cnt  <= cnt + WIDTH'(1);
            tick <= 1'b0;
            done <= 1'b0;
        end
    end

    // A divisor accepted on a boundary edge is not applied until the next boundary.
    always_ff @(negedge clkMHz or negedge reset) begin
        if (!reset) begin
            div_active <= WIDTH'(DEFAULT_DIV);
            div_shadow <= WIDTH'(DEFAULT_DIV);
            pend       <= 1'b0;
        end else if (pend && ((state == IDLE) || boundary)) begin
            div_active <= div_shadow;
            pend       <= 1'b0;
        end else if (cfg_valid && !pend) begin
            div_shadow <= cfg_div;
            pend       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Bench for clkdiv_sched: a countdown-style reference model checked every cycle,
// plus directed scenarios with hand-computed expectations, then randomized traffic.
module tb_clkdiv_sched;

    localparam int WIDTH   = 18;
    localparam int DIV0    = 4;
    localparam int BURST_W = 8;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STOP  = 2;

    logic               clkMHz = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic [BURST_W-1:0] burst_len;
    logic               cfg_valid;
    logic [WIDTH-1:0]   cfg_div;
    logic               cfg_ready;
    logic               clkHz;
    logic               tick;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state: rem counts edges left until the next clkHz toggle.
    int       mode;
    int       rem;
    int       div_use;
    int       div_new;
    bit       pending;
    bit       m_clk;
    bit       m_tick;
    bit       m_done;
    bit [7:0] periods;
    bit [7:0] target;

    clkdiv_sched #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DIV0),
        .BURST_W    (BURST_W)
    ) dut (
        .clkMHz   (clkMHz),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .burst_len(burst_len),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .clkHz    (clkHz),
        .tick     (tick),
        .busy     (busy),
        .done     (done)
    );

    always #10 clkMHz = ~clkMHz;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode    = M_IDLE;
        rem     = 0;
        div_use = DIV0;
        div_new = DIV0;
        pending = 1'b0;
        m_clk   = 1'b0;
        m_tick  = 1'b0;
        m_done  = 1'b0;
        periods = '0;
        target  = '0;
    endtask

    task automatic model_step();
        bit toggle_now;
        bit falling;
        toggle_now = (mode != M_IDLE) && (rem == 1);
        if (pending && (mode == M_IDLE || toggle_now)) begin
            div_use = div_new;
            pending = 1'b0;
        end else if (cfg_valid && !pending) begin
            div_new = int'(cfg_div);
            pending = 1'b1;
        end
        m_tick = 1'b0;
        m_done = 1'b0;
        if (mode == M_IDLE) begin
            m_clk = 1'b0;
            if (start) begin
                mode    = M_RUN;
                rem     = div_use + 1;
                periods = '0;
                target  = burst_len;
            end
        end else if (mode == M_RUN && stop && !m_clk) begin
            mode  = M_IDLE;
            m_clk = 1'b0;
        end else if (toggle_now) begin
            m_tick  = 1'b1;
            falling = m_clk;
            m_clk   = !m_clk;
            rem     = div_use + 1;
            if (falling) begin
                periods = periods + 8'd1;
                if (mode == M_RUN && target != 0 && periods == target) begin
                    m_done = 1'b1;
                    mode   = M_IDLE;
                end else if (mode == M_STOP || stop) begin
                    mode = M_IDLE;
                end
            end
        end else begin
            rem = rem - 1;
            if (mode == M_RUN && stop) begin
                mode = M_STOP;
            end
        end
    endtask

    always @(negedge clkMHz or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            model_step();
        end
    end

    always @(posedge clkMHz) begin
        if (cmp_en) begin
            checkOutput("clkHz", clkHz, m_clk);
            checkOutput("tick", tick, m_tick);
            checkOutput("done", done, m_done);
            checkOutput("busy", busy, mode != M_IDLE);
            checkOutput("cfg_ready", cfg_ready, !pending);
        end
    end

    task automatic next_cycle();
        @(posedge clkMHz);
        #1;
    endtask

    task automatic wait_level(input logic lvl, input string name, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            next_cycle();
            n++;
            if (clkHz === lvl) return;
        end
        checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_tick(input string name, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            next_cycle();
            n++;
            if (tick === 1'b1) return;
        end
        checkOutput({name, "_timeout"}, 0, 1);
    endtask

    task automatic stop_run(input string name);
        for (int i = 0; i < 50; i++) begin
            stop = 1'b1;
            next_cycle();
            if (!busy) break;
        end
        stop = 1'b0;
        checkOutput(name, busy, 0);
    endtask

    task automatic applyStimulus();
        next_cycle();
        reset     = ($urandom_range(0, 599) != 0);
        start     = ($urandom_range(0, 9) == 0);
        stop      = ($urandom_range(0, 11) == 0);
        burst_len = BURST_W'($urandom_range(0, 4));
        cfg_valid = ($urandom_range(0, 4) == 0);
        cfg_div   = WIDTH'($urandom_range(0, 6));
    endtask

    initial begin
        int n;
        int hi;
        int ticks;
        int highs;
        int dones;
        logic prev;

        reset     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        burst_len = '0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (3) next_cycle();
        cmp_en = 1'b1;
        checkOutput("rst_clkHz", clkHz, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cfg_ready", cfg_ready, 1);
        checkOutput("rst_tick", tick, 0);
        checkOutput("rst_done", done, 0);
        reset = 1'b1;
        next_cycle();

        // Continuous run at the default divisor: 5-cycle halves.
        burst_len = '0;
        start     = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_level(1'b1, "first_rise", n);
        checkOutput("first_rise_edges", n, 5);
        checkOutput("busy_run", busy, 1);
        wait_level(1'b0, "high_half", n);
        checkOutput("high_half_len", n, 5);
        wait_level(1'b1, "low_half", n);
        checkOutput("low_half_len", n, 5);
        ticks = 0;
        repeat (20) begin
            next_cycle();
            ticks += int'(tick);
        end
        checkOutput("ticks_in_20", ticks, 4);

        // Divisor 9 offered mid half-period takes effect after the next boundary.
        wait_tick("pre_cfg", n);
        next_cycle();
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(9);
        next_cycle();
        cfg_valid = 1'b0;
        checkOutput("cfg_ready_pending", cfg_ready, 0);
        wait_tick("cfg_apply", n);
        checkOutput("cfg_ready_after_apply", cfg_ready, 1);
        wait_tick("long_half", n);
        checkOutput("half_len_div9", n, 10);

        next_cycle();
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(DIV0);
        next_cycle();
        cfg_valid = 1'b0;
        wait_tick("restore_apply", n);

        // Stop during the high half: high finishes its full length, no done.
        wait_level(1'b0, "pre_stop_low", n);
        wait_level(1'b1, "pre_stop_rise", n);
        hi = 1;
        for (int i = 0; i < 30; i++) begin
            stop = (hi == 2);
            next_cycle();
            if (!clkHz) break;
            hi++;
        end
        stop = 1'b0;
        checkOutput("stop_high_len", hi, 5);
        checkOutput("stop_high_busy", busy, 0);
        checkOutput("stop_high_done", done, 0);
        next_cycle();

        // Burst of three periods.
        burst_len = BURST_W'(3);
        start     = 1'b1;
        next_cycle();
        start = 1'b0;
        highs = 0;
        dones = 0;
        prev  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            if (clkHz && !prev) highs++;
            prev = clkHz;
            dones += int'(done);
            if (!busy) break;
        end
        checkOutput("burst_highs", highs, 3);
        checkOutput("burst_dones", dones, 1);
        checkOutput("burst_done_at_end", done, 1);
        checkOutput("burst_busy_end", busy, 0);
        checkOutput("burst_clk_end", clkHz, 0);
        next_cycle();
        checkOutput("burst_done_one_cycle", done, 0);
        checkOutput("burst_clk_stays_low", clkHz, 0);

        // Stop during the low half ends on the very next edge.
        burst_len = '0;
        start     = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_level(1'b1, "stop_low_rise", n);
        wait_level(1'b0, "stop_low_fall", n);
        next_cycle();
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        checkOutput("stop_low_busy", busy, 0);
        checkOutput("stop_low_clk", clkHz, 0);
        checkOutput("stop_low_done", done, 0);

        // Asynchronous reset mid burst while clkHz is high.
        burst_len = BURST_W'(5);
        start     = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_level(1'b1, "rst_mid_rise", n);
        next_cycle();
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_clk", clkHz, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_tick", tick, 0);
        checkOutput("rst_mid_done", done, 0);
        checkOutput("rst_mid_ready", cfg_ready, 1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        burst_len = '0;
        start     = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_level(1'b1, "post_rst_rise", n);
        checkOutput("post_rst_first_rise", n, 5);
        stop_run("post_rst_stop");

        // Divisor 0: clkHz toggles every edge.
        cfg_valid = 1'b1;
        cfg_div   = '0;
        next_cycle();
        cfg_valid = 1'b0;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        checkOutput("div0_first_high", clkHz, 1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("div0_tick", tick, 1);
            next_cycle();
        end
        stop_run("div0_stop");
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(DIV0);
        next_cycle();
        cfg_valid = 1'b0;
        repeat (2) next_cycle();

        for (int i = 0; i < 4000; i++) begin
            applyStimulus();
        end

        next_cycle();
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        repeat (3) next_cycle();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
